// File: rtl/fp_mant_div_seq_pkg.sv
// Shared FP divide constants and FSM state encoding for the sequential
// mantissa divider.
package fp_mant_div_seq_pkg;
  localparam int MW_DEF = 24;
  localparam int MANT_W = MW_DEF;
  localparam int QUOT_W = MW_DEF + 1;

  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;
endpackage

// File: rtl/fp_mant_div_seq_div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift left.
module div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic         qbit
);
  logic [W-1:0] diff;

  assign qbit   = (r >= d);
  assign diff   = qbit ? (r - d) : r;
  // diff < d keeps the top bit clear for non-zero d, so the shift loses nothing
  assign r_next = {diff[W-2:0], 1'b0};
endmodule

// File: rtl/fp_mant_div_seq.sv
// Iterative restoring mantissa divider: quot = floor({a_mant, MW'b0} / b_mant),
// one quotient bit per clock, MSB first.
module fp_mant_div_seq
  import fp_mant_div_seq_pkg::*;
#(
  parameter int MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  output logic          busy,
  output logic          done,
  output logic [MW:0]   quot,
  output logic          sticky,
  output logic          dz
);
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] LAST = CW'(MW);

  div_state_t    state, state_d;
  logic [MW:0]   r, d, r_next;
  logic [CW-1:0] cnt;
  logic [MW-1:0] q_sr;
  logic          qbit, accept, last;

  div_step #(.W(MW + 1)) u_step (
    .r      (r),
    .d      (d),
    .r_next (r_next),
    .qbit   (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      DIV_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = DIV_RUN;
      end
      DIV_RUN: if (cnt == LAST) begin
        last    = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign busy = (state == DIV_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r      <= '0;
      d      <= '0;
      cnt    <= '0;
      q_sr   <= '0;
      quot   <= '0;
      sticky <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        r    <= {1'b0, a_mant};
        d    <= {1'b0, b_mant};
        cnt  <= '0;
        q_sr <= '0;
        dz   <= 1'b0;
      end else if (state == DIV_RUN) begin
        r    <= r_next;
        cnt  <= cnt + 1'b1;
        q_sr <= {q_sr[MW-2:0], qbit};
        if (last) begin
          // zero divisor yields qbit=1 every step; remainder is meaningless, so force sticky
          quot   <= {q_sr, qbit};
          sticky <= (d == '0) | (|r_next);
          dz     <= (d == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Scoreboard bench for fp_mant_div_seq: expected results queued at start,
// compared (value and latency) when done pulses.
module tb_fp_mant_div_seq;
  localparam int MW = 24;

  logic          clk = 0, rst_n = 0, start = 0;
  logic [MW-1:0] a_mant = '0, b_mant = '0;
  logic          busy, done, sticky, dz;
  logic [MW:0]   quot;

  typedef struct {
    logic [MW:0] q;
    logic        s;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, n_chk = 0, n_pass = 0;

  fp_mant_div_seq #(.MW(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_mant(a_mant), .b_mant(b_mant),
    .busy(busy), .done(done), .quot(quot), .sticky(sticky), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b, input int c);
    exp_t e;
    logic [2*MW-1:0] n, qq, rr;
    e.cyc = c;
    if (b == 0) begin
      e.q = '1; e.s = 1'b1; e.z = 1'b1;
    end else begin
      n  = {a, {MW{1'b0}}};
      qq = n / {{MW{1'b0}}, b};
      rr = n % {{MW{1'b0}}, b};
      e.q = qq[MW:0]; e.s = (rr != 0); e.z = 1'b0;
    end
    return e;
  endfunction

  // Drive a one-cycle start pulse; queue an expectation if it should be accepted.
  task automatic go(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit acc);
    @(posedge clk); #1;
    start = 1; a_mant = a; b_mant = b;
    if (acc) sb.push_back(model(a, b, cyc + 1 + MW + 1));
    @(posedge clk); #1;
    start = 0; a_mant = $urandom; b_mant = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", 64'(quot), 64'(e.q));
        chk("sticky", 64'(sticky), 64'(e.s));
        chk("dz", 64'(dz), 64'(e.z));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    exp_t held;
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_quot", 64'(quot), 0);
    chk("rst_sticky", 64'(sticky), 0);
    chk("rst_dz", 64'(dz), 0);
    rst_n = 1;

    go(24'hC00000, 24'h800000, 1);
    for (int i = 0; i < MW; i++) begin
      @(negedge clk);
      chk("busy_run", 64'(busy), 1);
    end
    wait_drain();
    chk("idle_after", 64'(busy), 0);

    go(24'h800000, 24'hC00000, 1); wait_drain();
    go(24'hABCDEF, 24'hABCDEF, 1); wait_drain();
    go(24'hFFFFFF, 24'h800000, 1); wait_drain();
    for (int i = 0; i < 4; i++) begin
      go(24'h800000 | 24'($urandom), 24'h800000 | 24'($urandom), 1);
      wait_drain();
    end

    // divide by zero, then a valid start clears dz
    go(24'h900000, 24'h000000, 1); wait_drain();
    chk("dz_held", 64'(dz), 1);
    go(24'hA00000, 24'h900000, 1);
    @(negedge clk);
    chk("dz_cleared", 64'(dz), 0);
    wait_drain();

    // restarts mid-run ignored; restart in done cycle accepted
    held = model(24'hE12345, 24'h9ABCDE, 0);
    go(24'hE12345, 24'h9ABCDE, 1);
    repeat (3) @(posedge clk);
    go(24'h800001, 24'hFFFFFF, 0);
    repeat (3) @(posedge clk);
    go(24'h123456, 24'h000000, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!done && n < 100) begin @(negedge clk); n++; end
      if (!done) chk("done_timeout", 0, 1);
      start = 1; a_mant = 24'hC35000; b_mant = 24'hF00000;
      sb.push_back(model(24'hC35000, 24'hF00000, cyc + 1 + MW + 1));
      @(posedge clk); #1; start = 0;
      @(negedge clk);
      chk("b2b_busy", 64'(busy), 1);
      chk("quot_held", 64'(quot), 64'(held.q));
    end
    wait_drain();

    // reset mid-run: outputs clear immediately, no done follows
    go(24'hF0F0F0, 24'h8F8F8F, 0);
    repeat (12) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_quot", 64'(quot), 0);
    chk("mid_rst_sticky", 64'(sticky), 0);
    chk("mid_rst_dz", 64'(dz), 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (30) @(posedge clk);
    go(24'hF0F0F0, 24'h8F8F8F, 1); wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
